// File: rtl/uart_result_tx.sv
// uart_result_tx: serializes the SAD template-match verdict ("MATCH\r\n" or
// "NOMATCH\r\n") as back-to-back 8N1 frames and pulses UARTsendComplete
// once the final stop bit has been sent.
module uart_result_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] UARTsend,
  output logic       tx,
  output logic       UARTsendComplete,
  output logic       busy
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_idx_q;
  logic [3:0]  byte_idx_q;
  logic [3:0]  len_q;
  logic        nm_q;
  logic        armed_q;
  logic        tx_q;
  logic        done_q;
  logic        busy_q;

  logic [15:0] baud_d;
  logic        baud_end_d;
  logic [7:0]  byte_d;
  logic [2:0]  bit_next_d;
  logic        off_d;
  logic        last_byte_d;

  // Message ROM: nm selects NOMATCH, idx is the byte position in the message.
  function automatic logic [7:0] msg_byte(input logic nm, input logic [3:0] idx);
    logic [7:0] b;
    b = 8'hFF;
    if (nm) begin
      case (idx)
        4'd0: b = 8'h4E;
        4'd1: b = 8'h4F;
        4'd2: b = 8'h4D;
        4'd3: b = 8'h41;
        4'd4: b = 8'h54;
        4'd5: b = 8'h43;
        4'd6: b = 8'h48;
        4'd7: b = 8'h0D;
        4'd8: b = 8'h0A;
        default: b = 8'hFF;
      endcase
    end else begin
      case (idx)
        4'd0: b = 8'h4D;
        4'd1: b = 8'h41;
        4'd2: b = 8'h54;
        4'd3: b = 8'h43;
        4'd4: b = 8'h48;
        4'd5: b = 8'h0D;
        4'd6: b = 8'h0A;
        default: b = 8'hFF;
      endcase
    end
    return b;
  endfunction

  // Next-value helpers shared by the FSM and arming logic.
  always_comb begin
    baud_d      = baud_q + 16'd1;
    baud_end_d  = (baud_q == BAUD_LAST);
    byte_d      = msg_byte(nm_q, byte_idx_q);
    bit_next_d  = bit_idx_q + 3'd1;
    off_d       = (UARTsend[1] == UARTsend[0]);   // codes 0 and 3 mean OFF
    last_byte_d = (byte_idx_q == (len_q - 4'd1));
  end

  // Re-trigger guard: a code only fires after an OFF has been seen since the last DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed_q <= 1'b0;
    end else if (state_q == S_DONE) begin
      armed_q <= 1'b0;
    end else if (off_d) begin
      armed_q <= 1'b1;
    end
  end

  // Transmit FSM with registered tx / busy / complete outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      baud_q     <= 16'd0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 4'd0;
      len_q      <= 4'd0;
      nm_q       <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          baud_q <= 16'd0;
          if (armed_q && !off_d) begin
            state_q    <= S_START;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            nm_q       <= UARTsend[1];
            len_q      <= UARTsend[1] ? 4'd9 : 4'd7;
            byte_idx_q <= 4'd0;
            bit_idx_q  <= 3'd0;
          end
        end
        S_START: begin
          if (baud_end_d) begin
            baud_q    <= 16'd0;
            state_q   <= S_DATA;
            bit_idx_q <= 3'd0;
            tx_q      <= byte_d[0];
          end else begin
            baud_q <= baud_d;
          end
        end
        S_DATA: begin
          if (baud_end_d) begin
            baud_q <= 16'd0;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_next_d;
              tx_q      <= byte_d[bit_next_d];
            end
          end else begin
            baud_q <= baud_d;
          end
        end
        S_STOP: begin
          if (baud_end_d) begin
            baud_q <= 16'd0;
            if (last_byte_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              byte_idx_q <= byte_idx_q + 4'd1;
              state_q    <= S_START;
              tx_q       <= 1'b0;
            end
          end else begin
            baud_q <= baud_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          tx_q    <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx               = tx_q;
  assign UARTsendComplete = done_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_uart_result_tx.sv
// tb_uart_result_tx: scoreboard bench for uart_result_tx at CLKS_PER_BIT=4.
// Stimulus pushes expected bytes, start cycles and message lengths into
// queues; independent monitors decode tx and watch busy/complete and pop them.
module tb_uart_result_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic [1:0] usend;
  logic       tx;
  logic       done;
  logic       busy;

  int checks;
  int errors;
  int cyc;

  logic [7:0] exp_bytes[$];
  int         exp_start[$];
  int         exp_n[$];

  logic [7:0] match_msg [7] = '{8'h4D, 8'h41, 8'h54, 8'h43, 8'h48, 8'h0D, 8'h0A};
  logic [7:0] nm_msg    [9] = '{8'h4E, 8'h4F, 8'h4D, 8'h41, 8'h54, 8'h43, 8'h48, 8'h0D, 8'h0A};

  uart_result_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clock            (clk),
    .reset            (rst),
    .UARTsend         (usend),
    .tx               (tx),
    .UARTsendComplete (done),
    .busy             (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte decoder: start bit seen at a negedge, bit k sampled CPB*(k+1)+1 negedges later.
  initial begin : rx_mon
    logic [7:0] rx;
    logic       stop;
    logic       aborted;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        aborted = 1'b0;
        rx      = 8'h00;
        stop    = 1'b0;
        for (int off = 1; off <= 9*CPB + 1; off++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (((off - 1) % CPB) == 0 && ((off - 1) / CPB) >= 1) begin
            if (((off - 1) / CPB) <= 8) rx[((off - 1) / CPB) - 1] = tx;
            else stop = tx;
          end
        end
        if (!aborted) begin
          checks++;
          if (exp_bytes.size() == 0) begin
            errors++;
            $display("FAIL rx_byte: unexpected byte %02h (stop=%0b), none expected", rx, stop);
          end else begin
            e = exp_bytes.pop_front();
            if (rx !== e || stop !== 1'b1) begin
              errors++;
              $display("FAIL rx_byte: got %02h stop=%0b, expected %02h stop=1", rx, stop, e);
            end
          end
        end
      end
    end
  end

  // busy / complete monitor.
  initial begin : ctl_mon
    logic busy_prev;
    int   busy_cnt;
    int   t_start;
    int   cur_n;
    int   es;
    int   n;
    busy_prev = 1'b0;
    busy_cnt  = 0;
    t_start   = 0;
    cur_n     = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1 && busy_prev === 1'b0) begin
        checks++;
        if (exp_start.size() == 0) begin
          errors++;
          $display("FAIL busy_rise: unexpected message start at cycle %0d", cyc);
        end else begin
          es = exp_start.pop_front();
          if (cyc != es) begin
            errors++;
            $display("FAIL busy_rise: started at cycle %0d, expected %0d", cyc, es);
          end
        end
        t_start  = cyc;
        busy_cnt = 0;
      end
      if (busy === 1'b1) busy_cnt++;
      if (done !== 1'b0) begin
        checks++;
        if (exp_n.size() == 0) begin
          errors++;
          $display("FAIL complete: unexpected pulse at cycle %0d", cyc);
        end else begin
          n = exp_n.pop_front();
          if ((cyc - t_start) != n*10*CPB || busy !== 1'b1) begin
            errors++;
            $display("FAIL complete: at %0d cycles after trigger busy=%0b, expected %0d with busy=1",
                     cyc - t_start, busy, n*10*CPB);
          end
          cur_n = n;
        end
      end
      if (busy === 1'b0 && busy_prev === 1'b1) begin
        if (!rst) begin
          checks++;
          if (busy_cnt != cur_n*10*CPB + 1) begin
            errors++;
            $display("FAIL busy_len: busy high %0d cycles, expected %0d", busy_cnt, cur_n*10*CPB + 1);
          end
        end
        cur_n = 0;
      end
      busy_prev = busy;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a code at a negedge and record what the DUT must produce.
  task automatic issue(input logic [1:0] code, input int nbytes);
    usend = code;
    exp_start.push_back(cyc + 1);
    if (code == 2'd1) begin
      for (int i = 0; i < nbytes; i++) exp_bytes.push_back(match_msg[i]);
      if (nbytes == 7) exp_n.push_back(7);
    end else begin
      for (int i = 0; i < nbytes; i++) exp_bytes.push_back(nm_msg[i]);
      if (nbytes == 9) exp_n.push_back(9);
    end
  endtask

  task automatic wait_complete(input int bound);
    int k;
    k = 0;
    while (done !== 1'b1 && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (k >= bound) begin
      checks++;
      errors++;
      $display("FAIL wait_complete: no complete pulse within %0d cycles", bound);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    usend  = 2'd0;
    tick(3);
    chk("reset_tx", int'(tx), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    #2 rst = 1'b0;
    tick(3);

    // MATCH held until complete.
    @(negedge clk);
    issue(2'd1, 7);
    wait_complete(400);
    tick(2);
    usend = 2'd0;
    tick(3);

    // NOT_MATCH held until complete.
    issue(2'd2, 9);
    wait_complete(500);
    tick(2);
    usend = 2'd0;
    tick(3);

    // MATCH held 50 cycles past complete, one OFF cycle, then NOT_MATCH.
    issue(2'd1, 7);
    wait_complete(400);
    tick(50);
    chk("held_no_retrigger_busy", int'(busy), 0);
    chk("held_no_retrigger_tx", int'(tx), 1);
    usend = 2'd0;
    tick(1);
    issue(2'd2, 9);
    wait_complete(500);
    tick(2);
    usend = 2'd0;
    tick(3);

    // Reset in the middle of bit 2 of byte 2.
    issue(2'd1, 2);
    tick(94);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_tx", int'(tx), 1);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_done", int'(done), 0);
    tick(2);
    #2 rst = 1'b0;
    tick(60);
    chk("post_reset_idle_busy", int'(busy), 0);
    chk("post_reset_idle_tx", int'(tx), 1);

    // Code 3 behaves as OFF.
    usend = 2'd3;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL code3_idle: tx=%0b busy=%0b at step %0d, expected tx=1 busy=0", tx, busy, i);
      end else begin
        checks++;
      end
    end

    // MATCH then switch to NOT_MATCH mid-message.
    issue(2'd1, 7);
    tick(100);
    usend = 2'd2;
    wait_complete(400);
    tick(20);
    chk("switch_no_retrigger_busy", int'(busy), 0);
    usend = 2'd0;
    tick(10);

    chk("leftover_bytes", exp_bytes.size(), 0);
    chk("leftover_starts", exp_start.size(), 0);
    chk("leftover_completes", exp_n.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_result_tx.md
# uart_result_tx

UART transmitter that reports the SAD template-match verdict to the host. It sits downstream of the SAD control unit and consumes its 2-bit `UARTsend` result code (0 = OFF, 1 = MATCH, 2 = NOT_MATCH). On a new code it serializes a fixed ASCII message as 8N1 frames on `tx`. When the last stop bit ends it returns a one-cycle `UARTsendComplete` pulse, which the control unit uses to leave its FINISH state.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (434 = 50 MHz / 115200). Legal range 2..65535.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  reset; one clock; asynchronous, active-high.
- `UARTsend`  in  2  result code from the control unit: 0 OFF, 1 MATCH, 2 NOT_MATCH. Code 3 is treated as OFF.
- `tx`  out  1  UART serial line; idles high.
- `UARTsendComplete`  out  1  one-cycle pulse after the final stop bit of a message.
- `busy`  out  1  high from the trigger edge until the `UARTsendComplete` pulse inclusive.

## Operation
- Messages, bytes sent in order, each byte LSB first:
  - MATCH = "MATCH\r\n": 4D 41 54 43 48 0D 0A (7 bytes).
  - NOT_MATCH = "NOMATCH\r\n": 4E 4F 4D 41 54 43 48 0D 0A (9 bytes).
  - Held in an internal constant ROM indexed by a 4-bit byte counter.
- Frame format: 1 start bit (0), 8 data bits, 1 stop bit (1), no parity. Bytes go back-to-back with no idle gap.
- FSM states:
  - IDLE: `tx`=1. Go to START when `armed` and `UARTsend` ∈ {1,2}. Latch the code and the message length; clear the byte index.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, CLKS_PER_BIT cycles each. The bit index counts 0..7, then go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. If more bytes remain, increment the byte index and go to START. Otherwise go to DONE.
  - DONE: one cycle, `UARTsendComplete`=1, `tx`=1, clear `armed`, then go to IDLE.
- Arming (re-trigger guard):
  - `armed` is cleared by reset and by DONE.
  - `armed` is set on any clock edge where `UARTsend` is OFF or 3.
  - This covers the control unit's registered `UARTsend`, which stays at MATCH/NOT_MATCH for at least one cycle after the complete pulse. A held code therefore never starts a second message.
- Once START is entered, the code is latched. Later changes to `UARTsend` are ignored until DONE.
- Baud counter: 16 bits, counts 0..CLKS_PER_BIT-1, reloads to 0 on every bit boundary and on entry to START.
- Reset, asynchronous, valid at any point including mid-bit:
  - Outputs: `tx`=1, `UARTsendComplete`=0, `busy`=0.
  - Internal: FSM=IDLE, all counters 0, `armed`=0.
  - No complete pulse is issued for an aborted message.

## Timing
- All outputs are registered; `tx` is glitch-free.
- Trigger at edge T, where `UARTsend` is sampled valid and `armed`=1:
  - `tx` falls and `busy` rises after edge T.
  - Each bit lasts exactly CLKS_PER_BIT cycles; each byte lasts 10·CLKS_PER_BIT cycles.
- `UARTsendComplete` is high for exactly the single cycle following the last stop bit.
  - This cycle starts N·10·CLKS_PER_BIT cycles after edge T, with N = 7 (MATCH) or N = 9 (NOT_MATCH).
- `busy` falls together with `UARTsendComplete`.
- The earliest next trigger is edge D+2, where D is the edge that ends DONE. It requires `UARTsend`=OFF sampled at edge D+1 or later.

## Test plan
Bench uses CLKS_PER_BIT=4.
- MATCH pulse held until complete:
  - `tx` decodes to 4D 41 54 43 48 0D 0A.
  - `UARTsendComplete` is high exactly one cycle, 280 cycles after the trigger edge.
  - `busy` is high 281 cycles.
- NOT_MATCH held until complete: `tx` decodes to 4E 4F 4D 41 54 43 48 0D 0A; complete pulse 360 cycles after the trigger.
- MATCH held 50 cycles past complete, then OFF, then NOT_MATCH:
  - No second MATCH message.
  - The NOT_MATCH message starts on the first valid edge after OFF.
- Assert reset mid-way through the third bit of byte 2:
  - `tx`=1 and `busy`=0 immediately (asynchronous).
  - No complete pulse.
  - With `UARTsend` still MATCH after release, nothing is sent until an OFF is seen.
- `UARTsend`=3 for 100 cycles: `tx` stays 1, `busy`=0.
- Switch `UARTsend` MATCH→NOT_MATCH mid-message: the remainder of the "MATCH\r\n" bytes is unaffected.
